sound_effects: RTL and testbench

//  Consumes the one-cycle event pulses from game physics: wall, paddle, block (with row) and ball-lost.

---
 rtl/sound_effects_pkg.sv | 33 +++
 rtl/sound_effects_tone_divider.sv | 29 ++
 rtl/sound_effects.sv | 156 +++++++++++++++
 tb/tb_sound_effects.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/sound_effects_pkg.sv
// Shared constants for the sound-effects block: FSM states, event priorities,
// internal widths and default tone timings derived from the board clock.
package sound_effects_pkg;

    localparam int CLK_HZ = 50_000_000;
    localparam int HALF_W = 18;
    localparam int DUR_W  = 25;

    // Half-period = CLK_HZ / (2 * f_tone); durations as fractions of a second.
    localparam int DEF_WALL_HALF       = CLK_HZ / (2 * 220);
    localparam int DEF_PADDLE_HALF     = CLK_HZ / (2 * 440);
    localparam int DEF_BLOCK_BASE_HALF = CLK_HZ / (2 * 880);
    localparam int DEF_BLOCK_STEP      = 2048;
    localparam int DEF_LOST_START_HALF = CLK_HZ / (2 * 440);
    localparam int DEF_LOST_STEP       = 64;
    localparam int DEF_TONE_CYCLES     = CLK_HZ / 25;
    localparam int DEF_LOST_CYCLES     = (CLK_HZ / 5) * 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TONE  = 2'd1,
        ST_SWEEP = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        PRIO_NONE   = 3'd0,
        PRIO_WALL   = 3'd1,
        PRIO_PADDLE = 3'd2,
        PRIO_BLOCK  = 3'd3,
        PRIO_LOST   = 3'd4
    } prio_t;

endpackage

// File: rtl/sound_effects_tone_divider.sv
// Half-period counter: pulses TOGGLE once every HALF cycles while RUN is high.
// LOAD restarts the count from zero and suppresses that cycle's toggle.
module tone_divider
    import sound_effects_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic [HALF_W-1:0] HALF,
    input  logic              LOAD,
    input  logic              RUN,
    output logic              TOGGLE
);

    logic [HALF_W-1:0] cnt_reg;
    logic              at_end;

    // >= keeps the counter from running away if HALF ever shrinks mid-count.
    assign at_end = (cnt_reg >= HALF - HALF_W'(1));
    assign TOGGLE = RUN && !LOAD && at_end;

    always_ff @(posedge CLK) begin
        if (RESET || LOAD) begin
            cnt_reg <= '0;
        end else if (RUN) begin
            cnt_reg <= at_end ? '0 : cnt_reg + HALF_W'(1);
        end
    end

endmodule

// File: rtl/sound_effects.sv
// Game sound effects: turns physics event pulses into prioritised square-wave
// tones (fixed-pitch blips and a falling ball-lost sweep) on one speaker pin.
module sound_effects
    import sound_effects_pkg::*;
#(
    parameter int WALL_HALF       = DEF_WALL_HALF,
    parameter int PADDLE_HALF     = DEF_PADDLE_HALF,
    parameter int BLOCK_BASE_HALF = DEF_BLOCK_BASE_HALF,
    parameter int BLOCK_STEP      = DEF_BLOCK_STEP,
    parameter int LOST_START_HALF = DEF_LOST_START_HALF,
    parameter int LOST_STEP       = DEF_LOST_STEP,
    parameter int TONE_CYCLES     = DEF_TONE_CYCLES,
    parameter int LOST_CYCLES     = DEF_LOST_CYCLES
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic       HIT_WALL,
    input  logic       HIT_PADDLE,
    input  logic       HIT_BLOCK,
    input  logic [2:0] HIT_BLOCK_ROW,
    input  logic       BALL_LOST,
    output logic       SPEAKER,
    output logic       BUSY
);

    localparam logic [DUR_W-1:0] TONE_LAST = DUR_W'(TONE_CYCLES - 1);
    localparam logic [DUR_W-1:0] LOST_LAST = DUR_W'(LOST_CYCLES - 1);

    state_t            state_reg, state_next;
    prio_t             prio_reg, prio_next;
    logic [HALF_W-1:0] half_reg, half_next;
    logic [DUR_W-1:0]  dur_reg, dur_next;
    logic              speaker_reg, speaker_next;
    logic              busy_reg, busy_next;

    prio_t             ev_prio;
    logic [HALF_W-1:0] ev_half;
    logic [HALF_W-1:0] block_half [8];
    logic [HALF_W:0]   sweep_sum;
    logic [HALF_W-1:0] sweep_half;
    logic              accept;
    logic              load;
    logic              run;
    logic              toggle;

    // Per-row block pitch table, wrapped to 18 bits.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_block_half
            assign block_half[gi] = HALF_W'(BLOCK_BASE_HALF - gi * BLOCK_STEP);
        end
    endgenerate

    // Priority encoder: only the most important simultaneous pulse survives.
    always_comb begin
        ev_prio = PRIO_NONE;
        ev_half = '0;
        if (BALL_LOST) begin
            ev_prio = PRIO_LOST;
            ev_half = HALF_W'(LOST_START_HALF);
        end else if (HIT_BLOCK) begin
            ev_prio = PRIO_BLOCK;
            ev_half = block_half[HIT_BLOCK_ROW];
        end else if (HIT_PADDLE) begin
            ev_prio = PRIO_PADDLE;
            ev_half = HALF_W'(PADDLE_HALF);
        end else if (HIT_WALL) begin
            ev_prio = PRIO_WALL;
            ev_half = HALF_W'(WALL_HALF);
        end
    end

    // Sweep lengthens the half-period, pinning at the 18-bit ceiling.
    assign sweep_sum  = {1'b0, half_reg} + (HALF_W + 1)'(LOST_STEP);
    assign sweep_half = sweep_sum[HALF_W] ? '1 : sweep_sum[HALF_W-1:0];

    assign run = (state_reg != ST_IDLE);

    tone_divider u_divider (
        .CLK    (CLK),
        .RESET  (RESET),
        .HALF   (half_reg),
        .LOAD   (load),
        .RUN    (run),
        .TOGGLE (toggle)
    );

    always_comb begin
        state_next   = state_reg;
        prio_next    = prio_reg;
        half_next    = half_reg;
        dur_next     = dur_reg;
        speaker_next = speaker_reg;
        load         = 1'b0;
        accept       = 1'b0;

        case (state_reg)
            ST_IDLE:  accept = (ev_prio != PRIO_NONE);
            ST_TONE:  accept = (ev_prio != PRIO_NONE) && (ev_prio >= prio_reg);
            default:  accept = 1'b0;
        endcase

        if (!ENABLE) begin
            state_next   = ST_IDLE;
            prio_next    = PRIO_NONE;
            dur_next     = '0;
            speaker_next = 1'b0;
        end else if (accept) begin
            load         = 1'b1;
            state_next   = (ev_prio == PRIO_LOST) ? ST_SWEEP : ST_TONE;
            prio_next    = ev_prio;
            half_next    = ev_half;
            dur_next     = '0;
            speaker_next = 1'b0;
        end else if (state_reg != ST_IDLE) begin
            if (dur_reg == ((state_reg == ST_SWEEP) ? LOST_LAST : TONE_LAST)) begin
                state_next   = ST_IDLE;
                prio_next    = PRIO_NONE;
                dur_next     = '0;
                speaker_next = 1'b0;
            end else begin
                dur_next = dur_reg + DUR_W'(1);
                if (toggle) begin
                    speaker_next = ~speaker_reg;
                    if (state_reg == ST_SWEEP) begin
                        half_next = sweep_half;
                    end
                end
            end
        end

        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg   <= ST_IDLE;
            prio_reg    <= PRIO_NONE;
            half_reg    <= '0;
            dur_reg     <= '0;
            speaker_reg <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            prio_reg    <= prio_next;
            half_reg    <= half_next;
            dur_reg     <= dur_next;
            speaker_reg <= speaker_next;
            busy_reg    <= busy_next;
        end
    end

    assign SPEAKER = speaker_reg;
    assign BUSY    = busy_reg;

endmodule

// File: tb/tb_sound_effects.sv
// Directed bench for sound_effects with shortened tone timings; every expected
// value below is hand-derived from the behavioural description.
module tb_sound_effects;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       ENABLE = 1'b0;
    logic       HIT_WALL = 1'b0;
    logic       HIT_PADDLE = 1'b0;
    logic       HIT_BLOCK = 1'b0;
    logic [2:0] HIT_BLOCK_ROW = 3'd0;
    logic       BALL_LOST = 1'b0;
    logic       SPEAKER;
    logic       BUSY;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    int t0        = 0;
    int n;

    sound_effects #(
        .WALL_HALF       (10),
        .PADDLE_HALF     (6),
        .BLOCK_BASE_HALF (40),
        .BLOCK_STEP      (4),
        .LOST_START_HALF (8),
        .LOST_STEP       (2),
        .TONE_CYCLES     (100),
        .LOST_CYCLES     (300)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .ENABLE        (ENABLE),
        .HIT_WALL      (HIT_WALL),
        .HIT_PADDLE    (HIT_PADDLE),
        .HIT_BLOCK     (HIT_BLOCK),
        .HIT_BLOCK_ROW (HIT_BLOCK_ROW),
        .BALL_LOST     (BALL_LOST),
        .SPEAKER       (SPEAKER),
        .BUSY          (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int k);
        while (cyc - t0 < k) step();
    endtask

    task automatic check(input string tag, input int got, input int exp);
        total_cnt++;
        assert (got === exp) pass_cnt++;
        else $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc - t0);
    endtask

    // One-cycle pulse, sampled at the next edge.
    task automatic fire(input logic w, input logic p, input logic b,
                        input logic [2:0] row, input logic l);
        HIT_WALL = w; HIT_PADDLE = p; HIT_BLOCK = b; HIT_BLOCK_ROW = row; BALL_LOST = l;
        step();
        HIT_WALL = 0; HIT_PADDLE = 0; HIT_BLOCK = 0; HIT_BLOCK_ROW = 0; BALL_LOST = 0;
    endtask

    // Cycles until SPEAKER changes; bounded so a dead speaker still terminates.
    task automatic wait_toggle(output int cycles);
        logic s;
        s = SPEAKER;
        cycles = 0;
        while (SPEAKER === s && cycles < 400) begin
            step();
            cycles++;
        end
    endtask

    initial begin
        // Reset
        step(); step();
        check("reset_speaker", int'(SPEAKER), 0);
        check("reset_busy", int'(BUSY), 0);
        RESET = 0;
        ENABLE = 1;
        step();

        // 1: wall tone, half 10, 100 cycles
        fire(1, 0, 0, 3'd0, 0); t0 = cyc;
        check("wall_busy_start", int'(BUSY), 1);
        check("wall_spk_start", int'(SPEAKER), 0);
        run_to(9);   check("wall_spk_k9", int'(SPEAKER), 0);
        run_to(10);  check("wall_spk_k10", int'(SPEAKER), 1);
        run_to(19);  check("wall_spk_k19", int'(SPEAKER), 1);
        run_to(20);  check("wall_spk_k20", int'(SPEAKER), 0);
        run_to(99);  check("wall_busy_k99", int'(BUSY), 1);
        run_to(100); check("wall_busy_k100", int'(BUSY), 0);
        check("wall_spk_k100", int'(SPEAKER), 0);

        // 2: block row 3 (half 28), lower-priority wall dropped, row 0 retrigger
        step();
        fire(0, 0, 1, 3'd3, 0); t0 = cyc;
        wait_toggle(n); check("block3_period", n, 28);
        run_to(30);
        fire(1, 0, 0, 3'd0, 0);
        check("wall_dropped_busy", int'(BUSY), 1);
        wait_toggle(n); check("wall_dropped_next_toggle", n, 25);
        run_to(60);
        fire(0, 0, 1, 3'd0, 0); t0 = cyc;
        check("retrig_spk", int'(SPEAKER), 0);
        check("retrig_busy", int'(BUSY), 1);
        wait_toggle(n); check("block0_period", n, 40);
        run_to(99);  check("retrig_busy_k99", int'(BUSY), 1);
        run_to(100); check("retrig_busy_k100", int'(BUSY), 0);

        // 2b: block row 7 beats a simultaneous paddle, half 12
        step();
        fire(0, 1, 1, 3'd7, 0); t0 = cyc;
        wait_toggle(n); check("block7_period_a", n, 12);
        wait_toggle(n); check("block7_period_b", n, 12);
        run_to(100); check("block7_end", int'(BUSY), 0);

        // 3: simultaneous pulses -> sweep 8,10,12,14,...; block ignored; 300 cycles
        step();
        fire(1, 1, 0, 3'd0, 1); t0 = cyc;
        check("sweep_busy", int'(BUSY), 1);
        wait_toggle(n); check("sweep_half0", n, 8);
        wait_toggle(n); check("sweep_half1", n, 10);
        wait_toggle(n); check("sweep_half2", n, 12);
        wait_toggle(n); check("sweep_half3", n, 14);
        fire(0, 0, 1, 3'd0, 0);
        wait_toggle(n); check("sweep_ignores_block", n, 15);
        run_to(299); check("sweep_busy_k299", int'(BUSY), 1);
        run_to(300); check("sweep_busy_k300", int'(BUSY), 0);
        check("sweep_spk_k300", int'(SPEAKER), 0);

        // 4: paddle, then mute
        step();
        fire(0, 1, 0, 3'd0, 0); t0 = cyc;
        run_to(20);
        check("paddle_spk_k20", int'(SPEAKER), 1);
        check("paddle_busy_k20", int'(BUSY), 1);
        ENABLE = 0;
        step();
        check("mute_spk", int'(SPEAKER), 0);
        check("mute_busy", int'(BUSY), 0);
        fire(0, 0, 1, 3'd0, 0);
        fire(0, 0, 0, 3'd0, 1);
        fire(1, 0, 0, 3'd0, 0);
        repeat (12) step();
        check("muted_event_busy", int'(BUSY), 0);
        check("muted_event_spk", int'(SPEAKER), 0);
        ENABLE = 1;
        step();

        // 5: reset mid-sweep, then a normal wall tone
        fire(0, 0, 0, 3'd0, 1); t0 = cyc;
        run_to(65);
        check("presreset_spk", int'(SPEAKER), 1);
        RESET = 1;
        step();
        check("midreset_spk", int'(SPEAKER), 0);
        check("midreset_busy", int'(BUSY), 0);
        RESET = 0;
        step();
        fire(1, 0, 0, 3'd0, 0); t0 = cyc;
        check("postreset_busy", int'(BUSY), 1);
        wait_toggle(n); check("postreset_period_a", n, 10);
        wait_toggle(n); check("postreset_period_b", n, 10);
        run_to(100); check("postreset_end", int'(BUSY), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
